// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the push-button debouncer:
//   btn_state_t               - debouncer FSM state encoding
//   DEFAULT_DEBOUNCE_CYCLES   - 10 ms stability window at 12 MHz
//   DEFAULT_LONG_PRESS_CYCLES - 1 s long-press threshold at 12 MHz
//   COUNT_W                   - width of the accepted-press counter (LED4..LED0)
// ---------------------------------------------------------------------------
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } btn_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES   = 120000;
  localparam int DEFAULT_LONG_PRESS_CYCLES = 12000000;
  localparam int COUNT_W                   = 5;

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous bit.
//   CLK - destination clock
//   RST - synchronous active-high reset, loads both flops with RESET_VAL
//   D   - asynchronous input
//   Q   - synchronized output (two CLK cycles of latency)
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= D;
      sync_reg <= meta_reg;
    end
  end

  assign Q = sync_reg;

endmodule

// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
// Debounces a raw push-button pin and derives press/release/long-press
// events plus a 5-bit accepted-press counter.
//   CLK           - 12 MHz clock
//   RST           - synchronous active-high reset
//   BTN           - raw asynchronous button pin (polarity set by ACTIVE_LOW)
//   PRESSED       - debounced level, 1 while the button is accepted as held
//   PRESS_PULSE   - one-cycle strobe when a press is accepted
//   RELEASE_PULSE - one-cycle strobe when a release is accepted
//   LONG_PULSE    - one-cycle strobe when a held press reaches
//                   LONG_PRESS_CYCLES
//   COUNT         - accepted-press counter, wraps 31 -> 0
// Edge-to-strobe latency is DEBOUNCE_CYCLES+3 for both press and release.
// ---------------------------------------------------------------------------
module button_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
  parameter bit ACTIVE_LOW        = 1'b1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               BTN,
  output logic               PRESSED,
  output logic               PRESS_PULSE,
  output logic               RELEASE_PULSE,
  output logic               LONG_PULSE,
  output logic [COUNT_W-1:0] COUNT
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES) + 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  generate
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("button_debounce: DEBOUNCE_CYCLES must be at least 2");
    end
    if (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long_press
      $error("button_debounce: LONG_PRESS_CYCLES must exceed DEBOUNCE_CYCLES");
    end
  endgenerate

  // Normalize polarity before synchronizing so the synchronizer reset value
  // always means "not pressed".
  logic btn_pressed;
  logic sync_pressed;

  assign btn_pressed = ACTIVE_LOW ? ~BTN : BTN;

  sync_2ff #(
    .RESET_VAL (1'b0)
  ) u_sync (
    .CLK (CLK),
    .RST (RST),
    .D   (btn_pressed),
    .Q   (sync_pressed)
  );

  btn_state_t         state_reg,         state_next;
  logic [DB_W-1:0]    db_cnt_reg,        db_cnt_next;
  logic [HOLD_W-1:0]  hold_cnt_reg,      hold_cnt_next;
  logic [COUNT_W-1:0] count_reg,         count_next;
  logic               press_pulse_reg,   press_pulse_next;
  logic               release_pulse_reg, release_pulse_next;
  logic               held_state;

  assign held_state = (state_reg == HELD) || (state_reg == DB_RELEASE);

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg         <= IDLE;
      db_cnt_reg        <= '0;
      hold_cnt_reg      <= '0;
      count_reg         <= '0;
      press_pulse_reg   <= 1'b0;
      release_pulse_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      db_cnt_reg        <= db_cnt_next;
      hold_cnt_reg      <= hold_cnt_next;
      count_reg         <= count_next;
      press_pulse_reg   <= press_pulse_next;
      release_pulse_reg <= release_pulse_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next         = state_reg;
    db_cnt_next        = db_cnt_reg;
    hold_cnt_next      = hold_cnt_reg;
    count_next         = count_reg;
    press_pulse_next   = 1'b0;
    release_pulse_next = 1'b0;

    // Hold time keeps running through release bounces and saturates so a
    // long hold can never wrap and retrigger LONG_PULSE.
    if (held_state && (hold_cnt_reg != HOLD_MAX)) begin
      hold_cnt_next = hold_cnt_reg + 1'b1;
    end

    unique case (state_reg)
      IDLE: begin
        if (sync_pressed) begin
          state_next  = DB_PRESS;
          db_cnt_next = '0;
        end
      end

      DB_PRESS: begin
        if (!sync_pressed) begin
          state_next = IDLE;
        end else if (db_cnt_reg == DB_LAST) begin
          state_next       = HELD;
          press_pulse_next = 1'b1;
          hold_cnt_next    = '0;
          count_next       = count_reg + 1'b1;
        end else begin
          db_cnt_next = db_cnt_reg + 1'b1;
        end
      end

      HELD: begin
        if (!sync_pressed) begin
          state_next  = DB_RELEASE;
          db_cnt_next = '0;
        end
      end

      DB_RELEASE: begin
        // The release strobe is raised while still in DB_RELEASE so that
        // PRESSED drops one cycle after RELEASE_PULSE; the release is
        // already accepted at that point, so the exit to IDLE is unconditional.
        if (release_pulse_reg) begin
          state_next = IDLE;
        end else if (sync_pressed) begin
          state_next = HELD;
        end else if (db_cnt_reg == DB_LAST) begin
          release_pulse_next = 1'b1;
        end else begin
          db_cnt_next = db_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    PRESSED       = held_state;
    PRESS_PULSE   = press_pulse_reg;
    RELEASE_PULSE = release_pulse_reg;
    LONG_PULSE    = held_state && (hold_cnt_reg == HOLD_LAST);
    COUNT         = count_reg;
  end

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;

  localparam int D          = 4;
  localparam int L          = 20;
  localparam bit ACTIVE_LOW = 1'b1;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic       pressed;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [4:0] count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: run lengths of the synchronized level, elapsed hold time
  bit m_pipe0, m_pipe1;
  bit m_pressed, m_rel_pending;
  bit m_press, m_rel, m_long;
  int m_ones, m_zeros, m_elapsed, m_count;

  // Event log taken from DUT outputs
  int n_press = 0, n_rel = 0, n_long = 0;
  int t_press = 0, t_rel = 0, t_long = 0, t_m_press = 0;

  always #5 clk = ~clk;

  button_debounce #(
    .DEBOUNCE_CYCLES   (D),
    .LONG_PRESS_CYCLES (L),
    .ACTIVE_LOW        (ACTIVE_LOW)
  ) dut (
    .CLK           (clk),
    .RST           (rst),
    .BTN           (btn),
    .PRESSED       (pressed),
    .PRESS_PULSE   (press_pulse),
    .RELEASE_PULSE (release_pulse),
    .LONG_PULSE    (long_pulse),
    .COUNT         (count)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // One clock edge of the reference model. The level seen by the debouncer
  // is the button two edges ago; a press is accepted once D+1 consecutive
  // pressed samples are seen, a release once D+1 consecutive released
  // samples are seen, and the edge after a release strobe is dead time.
  task automatic model_edge();
    bit s;
    if (rst) begin
      m_pipe0 = 0; m_pipe1 = 0;
      m_pressed = 0; m_rel_pending = 0;
      m_press = 0; m_rel = 0; m_long = 0;
      m_ones = 0; m_zeros = 0; m_elapsed = 0; m_count = 0;
    end else begin
      s       = m_pipe1;
      m_pipe1 = m_pipe0;
      m_pipe0 = ACTIVE_LOW ? !btn : btn;
      m_press = 0;
      m_rel   = 0;
      if (m_rel_pending) begin
        m_rel_pending = 0;
        m_pressed     = 0;
        m_ones        = 0;
      end else if (!m_pressed) begin
        m_ones = s ? m_ones + 1 : 0;
        if (m_ones == D + 1) begin
          m_press   = 1;
          m_pressed = 1;
          m_count   = (m_count + 1) % 32;
          m_elapsed = 0;
          m_zeros   = 0;
        end
      end else begin
        m_elapsed++;
        m_zeros = s ? 0 : m_zeros + 1;
        if (m_zeros == D + 1) begin
          m_rel         = 1;
          m_rel_pending = 1;
        end
      end
      m_long = m_pressed && (m_elapsed == L - 1);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t1, p0, r0, l0, len, pick;
    rst = 1'b1;
    btn = 1'b1;

    fork
      forever begin
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        if (press_pulse)   begin n_press++; t_press = cyc; end
        if (release_pulse) begin n_rel++;   t_rel   = cyc; end
        if (long_pulse)    begin n_long++;  t_long  = cyc; end
        if (m_press) t_m_press = cyc;
        check("PRESSED",       pressed,       m_pressed);
        check("PRESS_PULSE",   press_pulse,   m_press);
        check("RELEASE_PULSE", release_pulse, m_rel);
        check("LONG_PULSE",    long_pulse,    m_long);
        check("COUNT",         count,         m_count);
      end
    join_none

    // Reset state
    step(3);
    $display("reset: PRESSED=%0d COUNT=%0d", pressed, count);
    check("reset_pressed", pressed, 0);
    check("reset_count", count, 0);
    check("reset_press_pulse", press_pulse, 0);
    rst = 1'b0;
    step(5);

    // Clean press, then release
    t0 = cyc; btn = 1'b0; step(10);
    $display("clean press: latency=%0d COUNT=%0d", t_press - t0, count);
    check("clean_press_latency", t_press - t0, 7);
    check("model_press_latency", t_m_press - t0, 7);
    check("clean_pressed", pressed, 1);
    check("clean_count", count, 1);
    t1 = cyc; btn = 1'b1; step(8);
    $display("clean release: latency=%0d PRESSED=%0d", t_rel - t1, pressed);
    check("clean_release_latency", t_rel - t1, 7);
    check("clean_release_pressed", pressed, 0);

    // 3-cycle glitch
    step(5);
    p0 = n_press;
    btn = 1'b0; step(3); btn = 1'b1; step(15);
    $display("glitch: presses=%0d COUNT=%0d", n_press - p0, count);
    check("glitch_no_press", n_press - p0, 0);
    check("glitch_pressed", pressed, 0);
    check("glitch_count", count, 1);

    // Long press: hold 30 cycles
    l0 = n_long;
    t0 = cyc; btn = 1'b0; step(30);
    t1 = cyc; btn = 1'b1; step(12);
    $display("long press: press=%0d long_after=%0d release=%0d", t_press - t0, t_long - t_press, t_rel - t1);
    check("long_press_latency", t_press - t0, 7);
    check("long_after_press", t_long - t_press, 19);
    check("long_once", n_long - l0, 1);
    check("long_release_latency", t_rel - t1, 7);
    check("model_count_long", m_count, 2);

    // 2-cycle release bounce while held
    p0 = n_press; r0 = n_rel;
    btn = 1'b0; step(12);
    btn = 1'b1; step(2);
    btn = 1'b0; step(15);
    $display("bounce: presses=%0d releases=%0d PRESSED=%0d", n_press - p0, n_rel - r0, pressed);
    check("bounce_one_press", n_press - p0, 1);
    check("bounce_no_release", n_rel - r0, 0);
    check("bounce_pressed", pressed, 1);
    btn = 1'b1; step(12);
    check("bounce_count", count, 3);

    // Reset while held, button kept down -> fresh press
    btn = 1'b0; step(10);
    r0 = n_rel;
    rst = 1'b1; step(1);
    $display("reset while held: PRESSED=%0d COUNT=%0d", pressed, count);
    check("rst_held_pressed", pressed, 0);
    check("rst_held_count", count, 0);
    check("rst_held_no_release", n_rel - r0, 0);
    rst = 1'b0;
    t0 = cyc; step(10);
    $display("re-debounce after reset: latency=%0d COUNT=%0d", t_press - t0, count);
    check("rst_redebounce_latency", t_press - t0, 7);
    check("rst_redebounce_count", count, 1);
    check("rst_no_late_release", n_rel - r0, 0);
    btn = 1'b1; step(12);

    // 32 clean presses from a fresh reset
    rst = 1'b1; step(1); rst = 1'b0; step(3);
    p0 = n_press;
    for (int i = 0; i < 32; i++) begin
      btn = 1'b0; step(8);
      btn = 1'b1; step(10);
      $display("press %0d of 32: COUNT=%0d", i + 1, count);
    end
    check("wrap_presses", n_press - p0, 32);
    check("wrap_count", count, 0);

    // Randomized segments against the model
    for (int seg = 0; seg < 150; seg++) begin
      pick = $urandom_range(0, 99);
      if (pick < 4) begin
        len = $urandom_range(1, 2);
        rst = 1'b1; step(len); rst = 1'b0;
        $display("random seg %0d: reset %0d cycles", seg, len);
      end else begin
        btn = 1'($urandom_range(0, 1));
        len = (pick < 20) ? $urandom_range(20, 90) : $urandom_range(1, 12);
        step(len);
        $display("random seg %0d: BTN=%0d for %0d cycles, COUNT=%0d", seg, btn, len, count);
      end
    end

    btn = 1'b1; step(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The block SHALL expose parameter DEBOUNCE_CYCLES, default 120000, meaning the number of cycles an input level must be stable to be accepted (10 ms at 12 MHz).
REQ-002 The block SHALL expose parameter LONG_PRESS_CYCLES, default 12000000, meaning the number of HELD cycles before a long-press event (1 s at 12 MHz).
REQ-003 The block SHALL expose parameter ACTIVE_LOW, default 1, meaning BTN=0 denotes "pressed" when set.
REQ-004 The block SHALL have port CLK, input, 1 bit, 12MHz clock.
REQ-005 The block SHALL have port RST, input, 1 bit, synchronous active-high reset; one clock, no other clock domain.
REQ-006 The block SHALL have port BTN, input, 1 bit, raw asynchronous push-button pin.
REQ-007 The block SHALL have port PRESSED, output, 1 bit, debounced level, 1 while the button is accepted as held.
REQ-008 The block SHALL have port PRESS_PULSE, output, 1 bit, one-cycle strobe when a press is accepted.
REQ-009 The block SHALL have port RELEASE_PULSE, output, 1 bit, one-cycle strobe when a release is accepted.
REQ-010 The block SHALL have port LONG_PULSE, output, 1 bit, one-cycle strobe when a held press reaches LONG_PRESS_CYCLES.
REQ-011 The block SHALL have port COUNT, output, 5 bits, accepted-press counter sized to drive LED4..LED0 directly.

Function
REQ-012 BTN SHALL pass through a 2-flop synchronizer and be normalized so that sync=1 means "pressed" regardless of ACTIVE_LOW.
REQ-013 The FSM SHALL have the states IDLE, DB_PRESS, HELD and DB_RELEASE.
REQ-014 In IDLE, the FSM SHALL go to DB_PRESS when sync=1, with the stability counter cleared.
REQ-015 In DB_PRESS, sync=0 SHALL return the FSM to IDLE with no event.
REQ-016 In DB_PRESS, when sync=1 for DEBOUNCE_CYCLES consecutive cycles, the FSM SHALL enter HELD, assert PRESS_PULSE for exactly one cycle, clear the hold counter and increment COUNT.
REQ-017 Latency from a clean BTN press edge to PRESS_PULSE SHALL be exactly DEBOUNCE_CYCLES+3 cycles; release to RELEASE_PULSE SHALL have the same latency.
REQ-018 In HELD, sync=0 SHALL move the FSM to DB_RELEASE with the stability counter cleared.
REQ-019 In HELD and DB_RELEASE, the hold counter SHALL increment every cycle and saturate at LONG_PRESS_CYCLES; it SHALL NOT wrap.
REQ-020 LONG_PULSE SHALL fire once per accepted press, in the cycle the hold counter reaches LONG_PRESS_CYCLES-1, and SHALL NOT fire again until a new press is accepted.
REQ-021 In DB_RELEASE, sync=1 SHALL return the FSM to HELD, keeping the hold counter, with no event.
REQ-022 In DB_RELEASE, sync=0 for DEBOUNCE_CYCLES consecutive cycles SHALL move the FSM to IDLE and assert RELEASE_PULSE for one cycle.
REQ-023 PRESSED SHALL be 1 exactly in HELD and DB_RELEASE.
REQ-024 PRESSED SHALL go 1 in the same cycle as PRESS_PULSE and 0 in the cycle after RELEASE_PULSE.
REQ-025 COUNT SHALL wrap from 31 to 0 without any other effect.
REQ-026 PRESS_PULSE and RELEASE_PULSE SHALL never assert in the same cycle.
REQ-027 LONG_PULSE SHALL be able to coincide only with HELD or DB_RELEASE states.
REQ-028 Counter widths SHALL be $clog2 of the respective parameter plus 1.
REQ-029 Elaboration SHALL fail if DEBOUNCE_CYCLES<2 or LONG_PRESS_CYCLES<=DEBOUNCE_CYCLES.

Reset
REQ-030 While RST=1 at a CLK edge, the block SHALL enter IDLE and clear both synchronizer flops to "not pressed", the stability counter, the hold counter, COUNT=0 and all pulses=0, with PRESSED=0.
REQ-031 A reset asserted mid-press (any state) SHALL emit no RELEASE_PULSE.
REQ-032 After reset, a still-held button SHALL be re-debounced from IDLE and produce a fresh PRESS_PULSE.

Structure
REQ-033 Package btn_pkg SHALL hold the state enum type and the default DEBOUNCE_CYCLES and LONG_PRESS_CYCLES constants.
REQ-034 A single sub-module sync_2ff (1-bit, reset value parameter) SHALL implement the synchronizer; the FSM, counters and outputs SHALL remain in button_debounce.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, ACTIVE_LOW=1)
REQ-035 A clean press (BTN 1->0, held 10 cycles) SHALL produce PRESS_PULSE exactly 7 cycles after the edge, PRESSED=1 and COUNT 0->1.
REQ-036 A 3-cycle glitch (BTN low 3 cycles) SHALL produce no pulse, PRESSED=0 and COUNT unchanged.
REQ-037 A press held 30 cycles, then released, SHALL produce one LONG_PULSE 19 cycles after PRESS_PULSE, and RELEASE_PULSE 7 cycles after the release edge.
REQ-038 A 2-cycle release bounce in HELD SHALL produce no RELEASE_PULSE and no second PRESS_PULSE, with PRESSED held at 1.
REQ-039 32 clean presses SHALL return COUNT to 0; RST asserted while HELD SHALL produce PRESSED=0 next cycle with no RELEASE_PULSE.
